// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared types and helpers for the OV7670 capture stream.
//   state_e         capture state machine encoding
//   SYNC_DEPTH      flop depth of the camera bus synchroniser
//   DECIM_LOG2_MAX  largest supported decimation exponent
//   gray_to_rgb565  replicate an 8-bit luma sample into an RGB565 word
package ov7670_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_VS   = 2'd1,
    ST_WAIT_FALL = 2'd2,
    ST_ACTIVE    = 2'd3
  } state_e;

  localparam int SYNC_DEPTH     = 2;
  localparam int DECIM_LOG2_MAX = 3;

  // Grey pixel: the top luma bits feed every channel so white stays white.
  function automatic logic [15:0] gray_to_rgb565(input logic [7:0] y);
    return {y[7:3], y[7:2], y[7:3]};
  endfunction

endpackage

// File: rtl/ov7670_capture_stream_sync.sv
// cam_bus_sync: brings the camera bus into the clk domain.
//   clk_i, rst_ni        system clock, async active-low reset
//   cam_*_i              raw camera pins
//   pclk_rise_o          one-cycle pulse per camera pclk rising edge
//   vsync_rise_o/fall_o  one-cycle pulses on vsync edges
//   href_o, d_o          synchronised href and data, aligned with pclk_rise_o
module cam_bus_sync
  import ov7670_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cam_pclk_i,
  input  logic       cam_vsync_i,
  input  logic       cam_href_i,
  input  logic [7:0] cam_d_i,
  output logic       pclk_rise_o,
  output logic       vsync_rise_o,
  output logic       vsync_fall_o,
  output logic       href_o,
  output logic [7:0] d_o
);

  localparam int BUS_W = 11;

  // All pins share one chain so pclk, href and data stay mutually aligned.
  logic [SYNC_DEPTH-1:0][BUS_W-1:0] sync_q;
  logic [BUS_W-1:0]                 bus_s;
  logic                             pclk_d3_q;
  logic                             vsync_d3_q;

  assign bus_s = sync_q[SYNC_DEPTH-1];

  // Synchroniser shift chain plus the third-stage edge-detect flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      pclk_d3_q  <= 1'b0;
      vsync_d3_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_DEPTH-2:0], {cam_pclk_i, cam_vsync_i, cam_href_i, cam_d_i}};
      pclk_d3_q  <= bus_s[10];
      vsync_d3_q <= bus_s[9];
    end
  end

  assign pclk_rise_o  = bus_s[10] & ~pclk_d3_q;
  assign vsync_rise_o = bus_s[9] & ~vsync_d3_q;
  assign vsync_fall_o = ~bus_s[9] & vsync_d3_q;
  assign href_o       = bus_s[8];
  assign d_o          = bus_s[7:0];

endmodule

// File: rtl/ov7670_capture_stream.sv
// ov7670_capture_stream: camera bus to decimated pixel stream in the clk domain.
//   enable/single_shot/gray_mode  capture control
//   cam_*                         raw camera pins (sampled, not used as clocks)
//   pix_*                         valid/ready pixel output with coordinates
//   frame_start/frame_done        one-cycle frame pulses
//   busy, overflow, geom_err      status (overflow/geom_err sticky until reset)
//   frame_count/drop_count        completed frames (wraps), drops (saturates)
// Pipeline: sync(2) -> byte assembly -> decimation -> output register.
module ov7670_capture_stream
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int DECIM_LOG2 = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             single_shot,
  input  logic             gray_mode,
  input  logic             cam_pclk,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_d,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic [15:0]      pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic             overflow,
  output logic             geom_err,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count
);

  // Out-of-range exponents are clamped rather than producing a broken mask.
  localparam int DECIM_EFF = (DECIM_LOG2 > DECIM_LOG2_MAX) ? DECIM_LOG2_MAX :
                             ((DECIM_LOG2 < 0) ? 0 : DECIM_LOG2);
  localparam logic [X_W-1:0] X_MASK = X_W'((1 << DECIM_EFF) - 1);
  localparam logic [Y_W-1:0] Y_MASK = Y_W'((1 << DECIM_EFF) - 1);
  localparam logic [X_W-1:0] H_LIM  = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_LIM  = Y_W'(V_ACTIVE);

  logic       pclk_rise_s, vsync_rise_s, vsync_fall_s, href_s, href_fall_s;
  logic [7:0] d_s;

  state_e           state_q, state_d;
  logic             href_prev_q;
  logic [X_W-1:0]   x_q, x_d, cand_x_q, cand_x_d, emit_x_q, emit_x_d, pix_x_q, pix_x_d;
  logic [Y_W-1:0]   y_q, y_d, cand_y_q, cand_y_d, emit_y_q, emit_y_d, pix_y_q, pix_y_d;
  logic             phase_q, phase_d, shot_done_q, shot_done_d;
  logic [7:0]       hi_q, hi_d;
  logic             cand_valid_q, cand_valid_d, emit_valid_q, emit_valid_d;
  logic [15:0]      cand_data_q, cand_data_d, emit_data_q, pix_data_q, pix_data_d;
  logic             pix_valid_q, pix_valid_d;
  logic             frame_start_q, frame_start_d, frame_done_q, frame_done_d;
  logic             busy_q, overflow_q, overflow_d, geom_err_q, geom_err_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d, drop_count_q, drop_count_d;

  cam_bus_sync u_sync (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cam_pclk_i   (cam_pclk),
    .cam_vsync_i  (cam_vsync),
    .cam_href_i   (cam_href),
    .cam_d_i      (cam_d),
    .pclk_rise_o  (pclk_rise_s),
    .vsync_rise_o (vsync_rise_s),
    .vsync_fall_o (vsync_fall_s),
    .href_o       (href_s),
    .d_o          (d_s)
  );

  assign href_fall_s = href_prev_q & ~href_s;

  // Frame FSM, byte assembly and geometry check.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    cand_valid_d  = 1'b0;
    cand_data_d   = cand_data_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    geom_err_d    = geom_err_q;
    // A finished single shot stays parked until enable or single_shot drops.
    if (!enable || !single_shot) shot_done_d = 1'b0;
    else                         shot_done_d = shot_done_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !shot_done_q) state_d = ST_WAIT_VS;
        else                        state_d = ST_IDLE;
      end
      ST_WAIT_VS: begin
        if (!enable)           state_d = ST_IDLE;
        else if (vsync_rise_s) state_d = ST_WAIT_FALL;
        else                   state_d = ST_WAIT_VS;
      end
      ST_WAIT_FALL: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (vsync_fall_s) begin
          state_d       = ST_ACTIVE;
          frame_start_d = 1'b1;
          x_d           = '0;
          y_d           = '0;
          phase_d       = 1'b0;
        end else begin
          state_d = ST_WAIT_FALL;
        end
      end
      ST_ACTIVE: begin
        if (vsync_rise_s) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + CNT_W'(1);
          if (single_shot || !enable) begin
            state_d     = ST_IDLE;
            shot_done_d = single_shot & enable;
          end else begin
            state_d = ST_WAIT_FALL;
          end
        end else if (href_fall_s) begin
          // End of line; an odd trailing byte is simply forgotten.
          x_d     = '0;
          phase_d = 1'b0;
          if (y_q != V_LIM) y_d = y_q + Y_W'(1);
          else              y_d = y_q;
        end else if (pclk_rise_s && href_s) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = d_s;
          end else begin
            cand_data_d = gray_mode ? gray_to_rgb565(hi_q) : {hi_q, d_s};
            cand_x_d    = x_q;
            cand_y_d    = y_q;
            if ((x_q < H_LIM) && (y_q < V_LIM)) cand_valid_d = 1'b1;
            else                                geom_err_d   = 1'b1;
            if (x_q != H_LIM) x_d = x_q + X_W'(1);
            else              x_d = x_q;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decimation: keep only pixels on the 2^DECIM grid in both axes.
  always_comb begin
    emit_valid_d = cand_valid_q && ((cand_x_q & X_MASK) == '0) && ((cand_y_q & Y_MASK) == '0);
    emit_x_d     = cand_x_q >> DECIM_EFF;
    emit_y_d     = cand_y_q >> DECIM_EFF;
  end

  // Single-entry output register with drop accounting.
  always_comb begin
    pix_valid_d  = pix_valid_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_data_d   = pix_data_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (emit_valid_q) begin
      if (!pix_valid_q || pix_ready) begin
        pix_valid_d = 1'b1;
        pix_x_d     = emit_x_q;
        pix_y_d     = emit_y_q;
        pix_data_d  = emit_data_q;
      end else begin
        overflow_d = 1'b1;
        if (drop_count_q != {CNT_W{1'b1}}) drop_count_d = drop_count_q + CNT_W'(1);
        else                               drop_count_d = drop_count_q;
      end
    end else begin
      if (pix_valid_q && pix_ready) pix_valid_d = 1'b0;
      else                          pix_valid_d = pix_valid_q;
    end
  end

  // Capture-side state and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      href_prev_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      phase_q       <= 1'b0;
      hi_q          <= 8'h00;
      shot_done_q   <= 1'b0;
      cand_valid_q  <= 1'b0;
      cand_data_q   <= 16'h0000;
      cand_x_q      <= '0;
      cand_y_q      <= '0;
      emit_valid_q  <= 1'b0;
      emit_data_q   <= 16'h0000;
      emit_x_q      <= '0;
      emit_y_q      <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      geom_err_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      href_prev_q   <= href_s;
      x_q           <= x_d;
      y_q           <= y_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      shot_done_q   <= shot_done_d;
      cand_valid_q  <= cand_valid_d;
      cand_data_q   <= cand_data_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      emit_valid_q  <= emit_valid_d;
      emit_data_q   <= cand_data_q;
      emit_x_q      <= emit_x_d;
      emit_y_q      <= emit_y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= (state_d != ST_IDLE);
      geom_err_q    <= geom_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Output register and drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= 16'h0000;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_data_q   <= pix_data_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;
  assign geom_err    = geom_err_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_ov7670_capture_stream.sv
// Directed bench: dut0 is an 8x4 full-rate capture, dut1 the same geometry
// with 2x decimation. Both share the emulated camera bus.
module tb_ov7670_capture_stream;

  logic        clk = 1'b0;
  logic        rst_n, en0, en1, single_shot, gray_mode, pix_ready;
  logic        cam_pclk, cam_vsync, cam_href;
  logic [7:0]  cam_d;

  logic [9:0]  x0, x1;
  logic [8:0]  y0, y1;
  logic [15:0] d0, d1, fc0, fc1, dc0, dc1;
  logic        valid0, valid1, fs0, fs1, fd0, fd1, busy0, busy1;
  logic        ovf0, ovf1, gerr0, gerr1;

  int          n_vec = 0;
  int          n_miss = 0;
  int          n_fs0 = 0;
  int          n_fd0 = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  ov7670_capture_stream #(.H_ACTIVE(8), .V_ACTIVE(4), .X_W(10), .Y_W(9), .DECIM_LOG2(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .single_shot(single_shot), .gray_mode(gray_mode),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
    .pix_x(x0), .pix_y(y0), .pix_data(d0), .pix_valid(valid0), .pix_ready(pix_ready),
    .frame_start(fs0), .frame_done(fd0), .busy(busy0), .overflow(ovf0), .geom_err(gerr0),
    .frame_count(fc0), .drop_count(dc0));

  ov7670_capture_stream #(.H_ACTIVE(8), .V_ACTIVE(4), .X_W(10), .Y_W(9), .DECIM_LOG2(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .single_shot(single_shot), .gray_mode(gray_mode),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
    .pix_x(x1), .pix_y(y1), .pix_data(d1), .pix_valid(valid1), .pix_ready(1'b1),
    .frame_start(fs1), .frame_done(fd1), .busy(busy1), .overflow(ovf1), .geom_err(gerr1),
    .frame_count(fc1), .drop_count(dc1));

  function automatic logic [63:0] pk(input logic [9:0] x, input logic [8:0] y, input logic [15:0] d);
    return {29'd0, x, y, d};
  endfunction

  // Log every completed handshake and frame pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid0 && pix_ready) q0.push_back(pk(x0, y0, d0));
      if (valid1) q1.push_back(pk(x1, y1, d1));
      if (fs0) n_fs0++;
      if (fd0) n_fd0++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input int which, input string tag, input int idx, input logic [63:0] exp);
    logic [63:0] obs;
    obs = 64'hFFFF_FFFF_FFFF_FFFF;
    if (which == 0 && idx < q0.size()) obs = q0[idx];
    if (which == 1 && idx < q1.size()) obs = q1[idx];
    chk($sformatf("%s[%0d]", tag, idx), obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cam_byte(input logic [7:0] b);
    cam_d = b; cam_href = 1'b1; cam_pclk = 1'b0;
    tick(2);
    cam_pclk = 1'b1;
    tick(2);
  endtask

  task automatic cam_pix(input logic [15:0] p);
    cam_byte(p[15:8]);
    cam_byte(p[7:0]);
  endtask

  task automatic line_end();
    cam_pclk = 1'b0; cam_href = 1'b0;
    tick(4);
  endtask

  task automatic vs_pulse();
    cam_vsync = 1'b1;
    tick(6);
    cam_vsync = 1'b0;
    tick(6);
  endtask

  task automatic cam_frame(input int w, input int h, input logic [15:0] p);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) cam_pix(p);
      line_end();
    end
  endtask

  initial begin
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; single_shot = 1'b0; gray_mode = 1'b0;
    pix_ready = 1'b1; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
    #1;
    chk("reset_outs", {27'd0, valid0, fs0, fd0, busy0, ovf0, gerr0, fc0, dc0}, 64'd0);
    chk("reset_pix", pk(x0, y0, d0), 64'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("idle_busy", busy0, 1'b0);

    // RGB565 4x2 frame, plus a latency probe on the first pixel.
    q0.delete(); n_fs0 = 0; n_fd0 = 0;
    en0 = 1'b1; tick(2);
    vs_pulse();
    chk("armed_busy", busy0, 1'b1);
    cam_byte(8'hA5);
    cam_d = 8'h5A; cam_href = 1'b1; cam_pclk = 1'b0; tick(2);
    cam_pclk = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("latency_e3", valid0, 1'b0);
    @(posedge clk);
    @(negedge clk); chk("latency_e4", valid0, 1'b1);
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) cam_pix(16'hA55A);
    line_end();
    for (int i = 0; i < 4; i++) cam_pix(16'hA55A);
    line_end();
    en0 = 1'b0;
    vs_pulse(); tick(4);
    chk("rgb_count", q0.size(), 8);
    for (int i = 0; i < 8; i++) chk_q(0, "rgb_pix", i, pk(10'(i % 4), 9'(i / 4), 16'hA55A));
    chk("rgb_fstart", n_fs0, 1);
    chk("rgb_fdone", n_fd0, 1);
    chk("rgb_fcount", fc0, 16'd1);
    chk("rgb_idle", busy0, 1'b0);

    // Gray mode: Y,U,Y,V with Y = 0xFF then 0x80.
    q0.delete(); gray_mode = 1'b1; en0 = 1'b1; tick(2);
    vs_pulse();
    cam_byte(8'hFF); cam_byte(8'h00); cam_byte(8'h80); cam_byte(8'h00);
    line_end();
    en0 = 1'b0;
    vs_pulse(); tick(4);
    gray_mode = 1'b0;
    chk("gray_count", q0.size(), 2);
    chk_q(0, "gray_pix", 0, pk(10'd0, 9'd0, 16'hFFFF));
    chk_q(0, "gray_pix", 1, pk(10'd1, 9'd0, 16'h8410));

    // 2x decimation on an 8x4 frame (dut1 only).
    q0.delete(); q1.delete(); en1 = 1'b1; tick(2);
    vs_pulse();
    cam_frame(8, 4, 16'h1234);
    en1 = 1'b0;
    vs_pulse(); tick(4);
    chk("decim_count", q1.size(), 8);
    for (int i = 0; i < 8; i++) chk_q(1, "decim_pix", i, pk(10'(i % 4), 9'(i / 4), 16'h1234));
    chk("decim_dut0_quiet", q0.size(), 0);

    // Back-pressure: three pixels into a stalled output.
    q0.delete(); pix_ready = 1'b0; en0 = 1'b1; tick(2);
    vs_pulse();
    cam_pix(16'h1111); cam_pix(16'h2222); cam_pix(16'h3333);
    line_end(); tick(4);
    chk("stall_valid", valid0, 1'b1);
    chk("stall_held", pk(x0, y0, d0), pk(10'd0, 9'd0, 16'h1111));
    chk("stall_drops", dc0, 16'd2);
    chk("stall_overflow", ovf0, 1'b1);
    pix_ready = 1'b1; tick(2);
    chk("stall_drain_count", q0.size(), 1);
    chk_q(0, "stall_drain", 0, pk(10'd0, 9'd0, 16'h1111));
    chk("stall_drain_valid", valid0, 1'b0);
    en0 = 1'b0;
    vs_pulse();

    // Single shot over three camera frames.
    q0.delete(); n_fd0 = 0; single_shot = 1'b1; en0 = 1'b1; tick(2);
    for (int f = 0; f < 3; f++) begin
      vs_pulse();
      cam_pix(16'h4444);
      line_end();
    end
    vs_pulse(); tick(4);
    chk("shot_fdone", n_fd0, 1);
    chk("shot_busy", busy0, 1'b0);
    chk("shot_pixels", q0.size(), 1);
    chk("shot_fcount", fc0, 16'd4);
    en0 = 1'b0; single_shot = 1'b0; tick(2);

    // Over-long line: H_ACTIVE + 2 pixels.
    chk("geom_pre", gerr0, 1'b0);
    q0.delete(); en0 = 1'b1; tick(2);
    vs_pulse();
    for (int i = 0; i < 10; i++) cam_pix(16'h0F00 | 16'(i));
    line_end();
    en0 = 1'b0;
    vs_pulse(); tick(4);
    chk("geom_count", q0.size(), 8);
    for (int i = 0; i < 8; i++) chk_q(0, "geom_pix", i, pk(10'(i), 9'd0, 16'h0F00 | 16'(i)));
    chk("geom_err", gerr0, 1'b1);

    // Reset in the middle of a line.
    pix_ready = 1'b0; en0 = 1'b1; tick(2);
    vs_pulse();
    cam_pix(16'hBEEF); tick(3);
    cam_byte(8'h12);
    chk("prerst_valid", valid0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {27'd0, valid0, fs0, fd0, busy0, ovf0, gerr0, fc0, dc0}, 64'd0);
    chk("midrst_pix", pk(x0, y0, d0), 64'd0);
    tick(3);
    rst_n = 1'b1; pix_ready = 1'b1;
    q0.delete(); n_fs0 = 0;
    cam_byte(8'h34); cam_pix(16'h5678);
    line_end();
    chk("postrst_no_partial", q0.size(), 0);
    chk("postrst_no_start", n_fs0, 0);
    vs_pulse();
    cam_pix(16'h9ABC);
    line_end();
    en0 = 1'b0;
    vs_pulse(); tick(4);
    chk("resume_count", q0.size(), 1);
    chk_q(0, "resume_pix", 0, pk(10'd0, 9'd0, 16'h9ABC));
    chk("resume_fstart", n_fs0, 1);
    chk("resume_fcount", fc0, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ov7670_capture_stream.md
Name: ov7670_capture_stream

Overview:
- Parametrised successor to the OV7670 capture path; converts the raw camera bus (D[7:0], HREF, VSYNC, PCLK) into a pixel stream with coordinates, entirely in the system clock domain.
- Adds the following over the fixed 640x480 RGB565 capture:
  - configurable geometry
  - power-of-two decimation
  - RGB565 or luma-only mode
  - single-shot snapshot
  - valid/ready output with overflow accounting
- Sits between the camera pins and the frame-buffer RAM writer.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
X_W, 10, width of pix_x
Y_W, 9, width of pix_y
DECIM_LOG2, 0, decimation factor 2^DECIM_LOG2 in both axes (legal values 0..3)
CNT_W, 16, width of frame_count and drop_count

Ports:
clk  in  1  system clock; must be at least 4x cam_pclk frequency
rst_n  in  1  asynchronous active-low reset
enable  in  1  arm capture; sampled every cycle
single_shot  in  1  1 = capture one frame, then return to IDLE
gray_mode  in  1  0 = RGB565 byte pairs; 1 = YUV422, keep Y only
cam_pclk  in  1  camera pixel clock, sampled as data
cam_vsync  in  1  camera frame sync, active high
cam_href  in  1  camera line valid
cam_d  in  8  camera data byte
pix_x  out  X_W  output column (already decimated)
pix_y  out  Y_W  output row (already decimated)
pix_data  out  16  RGB565 pixel
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts pixel
frame_start  out  1  one-cycle pulse at start of a captured frame
frame_done  out  1  one-cycle pulse at end of a captured frame
busy  out  1  state is not IDLE
overflow  out  1  sticky; a pixel was dropped because the output was full
geom_err  out  1  sticky; a line or frame exceeded H_ACTIVE or V_ACTIVE
frame_count  out  CNT_W  completed frames; wraps modulo 2^CNT_W
drop_count  out  CNT_W  dropped pixels; saturates at all-ones

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; sticky flags 0.
- Input synchronisation:
  - cam_pclk, cam_vsync, cam_href and cam_d pass through one common 2-flop synchroniser so they stay mutually aligned.
  - A third pclk flop provides edge detection; pclk_rise = s2 & ~s3.
  - vsync rise and fall are detected the same way.
- States:
  - IDLE -> WAIT_VS when enable = 1.
  - WAIT_VS -> WAIT_FALL when a vsync rise is seen.
  - WAIT_FALL -> ACTIVE on vsync fall; frame_start pulses; x, y and byte phase clear.
  - ACTIVE -> on vsync rise: frame_done pulses and frame_count increments. Next state is IDLE if single_shot = 1 or enable = 0, otherwise WAIT_FALL.
  - enable = 0 in any state other than ACTIVE -> IDLE. In ACTIVE, the current frame is finished first.
- Byte assembly: on pclk_rise with href = 1 in ACTIVE, the byte phase toggles.
  - RGB565: first byte -> pix_data[15:8], second byte -> [7:0].
  - gray_mode: the first byte (Y) is kept and the second byte dropped. Output is {Y[7:3], Y[7:2], Y[7:3]}.
- Line handling:
  - href fall ends the line: y increments, x clears, byte phase clears.
  - An odd trailing byte is discarded without error.
- Geometry checks:
  - Pixels with x >= H_ACTIVE are dropped and set geom_err.
  - Lines with y >= V_ACTIVE are dropped and set geom_err.
  - Counters saturate at their limit and never wrap within a frame.
- Decimation: a pixel is emitted only if x[DECIM_LOG2-1:0] = 0 and y[DECIM_LOG2-1:0] = 0. Then pix_x = x >> DECIM_LOG2 and pix_y = y >> DECIM_LOG2.
- Latency: pix_valid rises 4 clk cycles after the first clk edge that samples cam_pclk high for the completing byte.
- Output handshake:
  - Single-entry output register.
  - pix_valid holds, with pix_x, pix_y and pix_data stable, until pix_valid & pix_ready.
  - A new pixel arriving while pix_valid = 1 and pix_ready = 0 is dropped; overflow sets and drop_count increments.
  - If pix_ready = 1 in the same cycle a new pixel arrives, the new pixel loads and nothing is dropped.
- Reset mid-frame: pix_valid clears immediately and state goes to IDLE. After release, the next full vsync cycle is required before capture resumes; partial frames are never emitted.
- The sticky flags clear only on reset.

Decomposition:
- Package ov7670_pkg holds:
  - the state enum
  - the synchroniser depth constant (2)
  - a gray-to-RGB565 expansion function
  - DECIM_LOG2 legality check constant
- One sub-module, cam_bus_sync: synchroniser plus edge detectors, producing pclk_rise, vsync_rise, vsync_fall, href_s and d_s.

Test Plan:
- RGB565 frame of 4x2 pixels, bytes 0xA5,0x5A repeated, pix_ready = 1 -> 8 pixels, data 0xA55A, (x,y) from (0,0) to (3,1); one frame_start, one frame_done; frame_count = 1.
- gray_mode with Y = 0xFF, U/V = 0x00 -> pix_data = 0xFFFF; with Y = 0x80 -> 0x8410.
- DECIM_LOG2 = 1 on an 8x4 frame -> 8 pixels, pix_x 0..3, pix_y 0..1.
- pix_ready = 0 for 3 pixel times -> first pixel held stable, 2 dropped; overflow = 1; drop_count = 2.
- single_shot = 1 over 3 camera frames -> exactly 1 frame_done; busy = 0 afterwards.
- Line of H_ACTIVE+2 pixels -> extra 2 pixels dropped; geom_err = 1. Reset mid-line -> all outputs 0; capture resumes only after the next full vsync cycle.
